punc_control: RTL and testbench
===============================

Name: punc_control

Overview:
Control FSM for the PUnC LC3 processor. It sits directly upstream of the PUnC datapath.
- Consumes the datapath's ir_out and nzp_match.
- Drives every datapath load, clear, read/write and select strobe.
- Sequences fetch/decode/execute for the LC3 subset, and parks permanently in HALT on opcode 1111.

Parameters:
None; all widths are fixed by the LC3 ISA (16-bit IR, 4-bit opcode at ir[15:12]).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ir  in  16  instruction register contents (datapath ir_out)
nzp_match  in  1  (IR[11:9] & NZP) != 0
pc_ld, pc_clr, pc_inc  out  1 each  PC load / clear / increment
pc_sel  out  2  0 = PC+sext(ir[8:0]), 1 = PC+sext(ir[10:0]), 2 = BaseR (rf_rp_data)
ir_ld, ir_clr  out  1 each  IR load / clear
mem_rd, mem_wr  out  1 each  memory read / write strobes
mem_r_addr_sel  out  2  0 = PC, 1 = PC+off9, 2 = BaseR+off6, 3 = temp
mem_w_addr_sel  out  2  0 = PC+off9, 1 = BaseR+off6, 2 = temp
rf_w_data_sel  out  2  0 = alu_out, 1 = mem data, 2 = PC+off9, 3 = PC
rf_w_addr_sel  out  1  0 = ir[11:9], 1 = R7
rf_w_wr  out  1  register write enable
rf_rp_addr_sel  out  1  0 = ir[8:6], 1 = ir[11:9]
rf_rp_rd, rf_rq_rd  out  1 each  RF read enables (rq addresses ir[2:0])
temp_ld  out  1  load temp from memory read data
nzp_ld, nzp_clr  out  1 each  condition code load / clear
alu_sel  out  2  0 = ADD, 1 = AND, 2 = NOT, 3 = PASS
alu_first_val_sel  out  1  0 = rf_rq_data, 1 = sext(ir[4:0]) (selected by ir[5])
halted  out  1  high while in HALT

Behaviour:
Reset and output style:
- rst high at a clock edge: state <= FETCH.
- While rst is high, all outputs are combinationally 0.
- Outputs are combinational from (state, ir, nzp_match). Any strobe not listed for a state/opcode is 0.

FETCH:
- Asserts mem_rd, mem_r_addr_sel = 0, ir_ld, pc_inc.
- Next state: DECODE. Memory read is combinational, so the IR is valid in DECODE.

DECODE:
- No strobes.
- Next state: HALT if ir[15:12] = 1111, else EXECUTE.

EXECUTE, by opcode:
- ADD 0001 / AND 0101:
  - rp_rd (sel 0), rq_rd.
  - alu_sel 0 or 1; alu_first_val_sel = ir[5].
  - rf_w_wr, data sel 0, addr sel 0, nzp_ld.
- NOT 1001: rp_rd, alu_sel 2, rf_w_wr, data sel 0, nzp_ld.
- BR 0000: if nzp_match, pc_ld with pc_sel 0; else no strobes.
- JMP 1100: rp_rd (sel 0), pc_ld, pc_sel 2.
- JSR/JSRR 0100:
  - rf_w_wr, addr sel 1, data sel 3, pc_ld.
  - pc_sel = ir[11] ? 1 : 2; rp_rd when ir[11] = 0.
  - Both R7 and PC sample the pre-edge PC/BaseR on the same edge, so JSRR R7 jumps to the old R7.
- LD 0010: mem_rd (sel 1), rf_w_wr, data sel 1, nzp_ld.
- LDR 0110: rp_rd, mem_rd (sel 2), rf_w_wr, data sel 1, nzp_ld.
- LEA 1110: rf_w_wr, data sel 2; nzp unchanged.
- ST 0011: rp_rd with sel 1, mem_wr (sel 0).
- STR 0111:
  - rp_rd with sel 1 supplies the source data.
  - mem_wr (sel 1).
  - BaseR is taken via rq: rq_rd, with the datapath routing ir[8:6] to rq for the base.
- LDI 1010 / STI 1011: mem_rd (sel 1), temp_ld; next state EXECUTE2.
- RTI 1000, reserved 1101: no strobes (NOP).

EXECUTE2:
- LDI: mem_rd (sel 3), rf_w_wr, data sel 1, nzp_ld.
- STI: rp_rd with sel 1, mem_wr (sel 2).

Transitions and latency:
- After EXECUTE (non-indirect ops) or EXECUTE2: next state FETCH.
- Latency is 3 cycles per instruction, 4 for LDI/STI.

HALT:
- halted = 1, no strobes, absorbing; exits only via rst.
- rst mid-instruction abandons it; no partial writes occur after the reset edge.

State encoding: 3 bits — FETCH, DECODE, EXECUTE, EXECUTE2, HALT. Unused codes go to FETCH.

Decomposition:
- Shared package (the team's Defines include): opcode constants, state encodings, and all *_sel encodings above. The datapath uses the same constants.
- No sub-module: a single state register plus a combinational output/next-state block.

Test Plan:
- rst high 2 cycles then low, ir = 16'h1042 (ADD R0,R1,R2) -> all outputs 0 during rst. Then FETCH: mem_rd = 1, ir_ld = 1, pc_inc = 1. DECODE: no strobes. EXECUTE: rf_w_wr = 1, alu_sel = 0, alu_first_val_sel = 0, nzp_ld = 1. Then back to FETCH.
- ir = 16'h0A05 (BRnp), nzp_match = 0 then 1 -> EXECUTE has pc_ld = 0 in the first case; pc_ld = 1, pc_sel = 0 in the second.
- ir = 16'hA203 (LDI R1) -> EXECUTE: mem_rd = 1, mem_r_addr_sel = 1, temp_ld = 1. EXECUTE2: mem_r_addr_sel = 3, rf_w_wr = 1, rf_w_data_sel = 1, nzp_ld = 1. FETCH on the 5th cycle.
- ir = 16'h4801 (JSR) -> EXECUTE: rf_w_addr_sel = 1, rf_w_data_sel = 3, rf_w_wr = 1, pc_ld = 1, pc_sel = 1.
- ir = 16'h41C0 (JSRR R7) -> EXECUTE: rf_w_addr_sel = 1, rf_w_data_sel = 3, rf_w_wr = 1, pc_ld = 1, pc_sel = 2, rf_rp_rd = 1.
- ir = 16'hF025 (HALT) -> halted = 1 from the cycle after DECODE, held for 20 cycles with all strobes 0. Pulsing rst returns the FSM to FETCH with halted = 0.
- ir = 16'hB405 (STI), rst asserted during EXECUTE -> next cycle all outputs 0, no mem_wr ever asserted, FETCH after rst drops.

Source files
------------

// File: rtl/punc_control_pkg.sv
// punc_control_pkg: shared definitions for the PUnC LC3 control unit and datapath.
//   - LC3 opcode constants (ir[15:12])
//   - control FSM state encoding
//   - encodings of every datapath select signal
package punc_control_pkg;

   // LC3 opcodes
   localparam logic [3:0] OpBr   = 4'b0000;
   localparam logic [3:0] OpAdd  = 4'b0001;
   localparam logic [3:0] OpLd   = 4'b0010;
   localparam logic [3:0] OpSt   = 4'b0011;
   localparam logic [3:0] OpJsr  = 4'b0100;
   localparam logic [3:0] OpAnd  = 4'b0101;
   localparam logic [3:0] OpLdr  = 4'b0110;
   localparam logic [3:0] OpStr  = 4'b0111;
   localparam logic [3:0] OpRti  = 4'b1000;
   localparam logic [3:0] OpNot  = 4'b1001;
   localparam logic [3:0] OpLdi  = 4'b1010;
   localparam logic [3:0] OpSti  = 4'b1011;
   localparam logic [3:0] OpJmp  = 4'b1100;
   localparam logic [3:0] OpRsv  = 4'b1101;
   localparam logic [3:0] OpLea  = 4'b1110;
   localparam logic [3:0] OpHalt = 4'b1111;

   typedef enum logic [2:0] {
      StFetch    = 3'd0,
      StDecode   = 3'd1,
      StExecute  = 3'd2,
      StExecute2 = 3'd3,
      StHalt     = 3'd4
   } state_e;

   // pc_sel
   localparam logic [1:0] PcSelOff9  = 2'd0;
   localparam logic [1:0] PcSelOff11 = 2'd1;
   localparam logic [1:0] PcSelBaseR = 2'd2;

   // mem_r_addr_sel
   localparam logic [1:0] MemRAddrPc        = 2'd0;
   localparam logic [1:0] MemRAddrPcOff9    = 2'd1;
   localparam logic [1:0] MemRAddrBaseROff6 = 2'd2;
   localparam logic [1:0] MemRAddrTemp      = 2'd3;

   // mem_w_addr_sel
   localparam logic [1:0] MemWAddrPcOff9    = 2'd0;
   localparam logic [1:0] MemWAddrBaseROff6 = 2'd1;
   localparam logic [1:0] MemWAddrTemp      = 2'd2;

   // rf_w_data_sel
   localparam logic [1:0] RfWDataAlu    = 2'd0;
   localparam logic [1:0] RfWDataMem    = 2'd1;
   localparam logic [1:0] RfWDataPcOff9 = 2'd2;
   localparam logic [1:0] RfWDataPc     = 2'd3;

   // rf_w_addr_sel
   localparam logic RfWAddrIr11_9 = 1'b0;
   localparam logic RfWAddrR7     = 1'b1;

   // rf_rp_addr_sel
   localparam logic RfRpAddrIr8_6  = 1'b0;
   localparam logic RfRpAddrIr11_9 = 1'b1;

   // alu_sel
   localparam logic [1:0] AluAdd  = 2'd0;
   localparam logic [1:0] AluAnd  = 2'd1;
   localparam logic [1:0] AluNot  = 2'd2;
   localparam logic [1:0] AluPass = 2'd3;

   // alu_first_val_sel
   localparam logic AluFirstRq   = 1'b0;
   localparam logic AluFirstImm5 = 1'b1;

   // LDI/STI need a second execute cycle to follow the pointer held in temp.
   function automatic logic is_indirect(logic [3:0] op);
      return (op == OpLdi) || (op == OpSti);
   endfunction

endpackage

// File: rtl/punc_control.sv
// punc_control: fetch/decode/execute control FSM for the PUnC LC3 processor.
// Inputs : clk_i, rst_i (sync, active-high), ir_i (instruction register),
//          nzp_match_i (branch condition satisfied).
// Outputs: PC controls (pc_ld/clr/inc, pc_sel), IR controls (ir_ld/clr),
//          memory strobes and address selects, register file write/read
//          controls, temp_ld, condition-code controls, ALU selects, halted.
// Outputs are combinational from (state, ir, nzp_match) and forced to 0
// while rst_i is high so an abandoned instruction never writes anything.
module punc_control
   import punc_control_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] ir_i,
   input  logic        nzp_match_i,
   output logic        pc_ld_o,
   output logic        pc_clr_o,
   output logic        pc_inc_o,
   output logic [1:0]  pc_sel_o,
   output logic        ir_ld_o,
   output logic        ir_clr_o,
   output logic        mem_rd_o,
   output logic        mem_wr_o,
   output logic [1:0]  mem_r_addr_sel_o,
   output logic [1:0]  mem_w_addr_sel_o,
   output logic [1:0]  rf_w_data_sel_o,
   output logic        rf_w_addr_sel_o,
   output logic        rf_w_wr_o,
   output logic        rf_rp_addr_sel_o,
   output logic        rf_rp_rd_o,
   output logic        rf_rq_rd_o,
   output logic        temp_ld_o,
   output logic        nzp_ld_o,
   output logic        nzp_clr_o,
   output logic [1:0]  alu_sel_o,
   output logic        alu_first_val_sel_o,
   output logic        halted_o
);

   state_e     state_q, state_d;
   logic [3:0] opcode;

   assign opcode = ir_i[15:12];

   // Operand fields are decoded by the datapath, not here.
   logic unused_ir;
   assign unused_ir = ^{ir_i[10:6], ir_i[4:0]};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d             = StFetch;
      pc_ld_o             = 1'b0;
      pc_clr_o            = 1'b0;
      pc_inc_o            = 1'b0;
      pc_sel_o            = PcSelOff9;
      ir_ld_o             = 1'b0;
      ir_clr_o            = 1'b0;
      mem_rd_o            = 1'b0;
      mem_wr_o            = 1'b0;
      mem_r_addr_sel_o    = MemRAddrPc;
      mem_w_addr_sel_o    = MemWAddrPcOff9;
      rf_w_data_sel_o     = RfWDataAlu;
      rf_w_addr_sel_o     = RfWAddrIr11_9;
      rf_w_wr_o           = 1'b0;
      rf_rp_addr_sel_o    = RfRpAddrIr8_6;
      rf_rp_rd_o          = 1'b0;
      rf_rq_rd_o          = 1'b0;
      temp_ld_o           = 1'b0;
      nzp_ld_o            = 1'b0;
      nzp_clr_o           = 1'b0;
      alu_sel_o           = AluAdd;
      alu_first_val_sel_o = AluFirstRq;
      halted_o            = 1'b0;

      if (!rst_i) begin
         case (state_q)
            StFetch: begin
               mem_rd_o         = 1'b1;
               mem_r_addr_sel_o = MemRAddrPc;
               ir_ld_o          = 1'b1;
               pc_inc_o         = 1'b1;
               state_d          = StDecode;
            end

            StDecode: begin
               state_d = (opcode == OpHalt) ? StHalt : StExecute;
            end

            StExecute: begin
               state_d = is_indirect(opcode) ? StExecute2 : StFetch;
               unique case (opcode)
                  OpAdd, OpAnd: begin
                     rf_rp_rd_o          = 1'b1;
                     rf_rq_rd_o          = 1'b1;
                     alu_sel_o           = (opcode == OpAdd) ? AluAdd : AluAnd;
                     alu_first_val_sel_o = ir_i[5];
                     rf_w_wr_o           = 1'b1;
                     rf_w_data_sel_o     = RfWDataAlu;
                     nzp_ld_o            = 1'b1;
                  end
                  OpNot: begin
                     rf_rp_rd_o      = 1'b1;
                     alu_sel_o       = AluNot;
                     rf_w_wr_o       = 1'b1;
                     rf_w_data_sel_o = RfWDataAlu;
                     nzp_ld_o        = 1'b1;
                  end
                  OpBr: begin
                     pc_ld_o  = nzp_match_i;
                     pc_sel_o = PcSelOff9;
                  end
                  OpJmp: begin
                     rf_rp_rd_o = 1'b1;
                     pc_ld_o    = 1'b1;
                     pc_sel_o   = PcSelBaseR;
                  end
                  OpJsr: begin
                     // R7 and PC both capture pre-edge values, so JSRR R7 works.
                     rf_w_wr_o       = 1'b1;
                     rf_w_addr_sel_o = RfWAddrR7;
                     rf_w_data_sel_o = RfWDataPc;
                     pc_ld_o         = 1'b1;
                     pc_sel_o        = ir_i[11] ? PcSelOff11 : PcSelBaseR;
                     rf_rp_rd_o      = ~ir_i[11];
                  end
                  OpLd: begin
                     mem_rd_o         = 1'b1;
                     mem_r_addr_sel_o = MemRAddrPcOff9;
                     rf_w_wr_o        = 1'b1;
                     rf_w_data_sel_o  = RfWDataMem;
                     nzp_ld_o         = 1'b1;
                  end
                  OpLdr: begin
                     rf_rp_rd_o       = 1'b1;
                     mem_rd_o         = 1'b1;
                     mem_r_addr_sel_o = MemRAddrBaseROff6;
                     rf_w_wr_o        = 1'b1;
                     rf_w_data_sel_o  = RfWDataMem;
                     nzp_ld_o         = 1'b1;
                  end
                  OpLea: begin
                     rf_w_wr_o       = 1'b1;
                     rf_w_data_sel_o = RfWDataPcOff9;
                  end
                  OpSt: begin
                     rf_rp_rd_o       = 1'b1;
                     rf_rp_addr_sel_o = RfRpAddrIr11_9;
                     mem_wr_o         = 1'b1;
                     mem_w_addr_sel_o = MemWAddrPcOff9;
                  end
                  OpStr: begin
                     // rp carries the source register; the base comes in on rq.
                     rf_rp_rd_o       = 1'b1;
                     rf_rp_addr_sel_o = RfRpAddrIr11_9;
                     rf_rq_rd_o       = 1'b1;
                     mem_wr_o         = 1'b1;
                     mem_w_addr_sel_o = MemWAddrBaseROff6;
                  end
                  OpLdi, OpSti: begin
                     mem_rd_o         = 1'b1;
                     mem_r_addr_sel_o = MemRAddrPcOff9;
                     temp_ld_o        = 1'b1;
                  end
                  OpRti, OpRsv, OpHalt: begin
                  end
               endcase
            end

            StExecute2: begin
               state_d = StFetch;
               if (opcode == OpLdi) begin
                  mem_rd_o         = 1'b1;
                  mem_r_addr_sel_o = MemRAddrTemp;
                  rf_w_wr_o        = 1'b1;
                  rf_w_data_sel_o  = RfWDataMem;
                  nzp_ld_o         = 1'b1;
               end else if (opcode == OpSti) begin
                  rf_rp_rd_o       = 1'b1;
                  rf_rp_addr_sel_o = RfRpAddrIr11_9;
                  mem_wr_o         = 1'b1;
                  mem_w_addr_sel_o = MemWAddrTemp;
               end
            end

            StHalt: begin
               halted_o = 1'b1;
               state_d  = StHalt;
            end

            default: begin
               state_d = StFetch;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_punc_control.sv
// tb_punc_control: scoreboard bench for punc_control. The stimulus process
// drives one cycle at a time and pushes the expected output vector produced
// by a step-counting instruction model; a monitor pops and compares at
// every falling edge.
module tb_punc_control;

   typedef struct packed {
      logic       pc_ld;
      logic       pc_clr;
      logic       pc_inc;
      logic [1:0] pc_sel;
      logic       ir_ld;
      logic       ir_clr;
      logic       mem_rd;
      logic       mem_wr;
      logic [1:0] mem_r_addr_sel;
      logic [1:0] mem_w_addr_sel;
      logic [1:0] rf_w_data_sel;
      logic       rf_w_addr_sel;
      logic       rf_w_wr;
      logic       rf_rp_addr_sel;
      logic       rf_rp_rd;
      logic       rf_rq_rd;
      logic       temp_ld;
      logic       nzp_ld;
      logic       nzp_clr;
      logic [1:0] alu_sel;
      logic       alu_first_val_sel;
      logic       halted;
   } out_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] ir = 16'h0000;
   logic        nzp_match = 1'b0;
   out_t        act;

   punc_control u_dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .ir_i                (ir),
      .nzp_match_i         (nzp_match),
      .pc_ld_o             (act.pc_ld),
      .pc_clr_o            (act.pc_clr),
      .pc_inc_o            (act.pc_inc),
      .pc_sel_o            (act.pc_sel),
      .ir_ld_o             (act.ir_ld),
      .ir_clr_o            (act.ir_clr),
      .mem_rd_o            (act.mem_rd),
      .mem_wr_o            (act.mem_wr),
      .mem_r_addr_sel_o    (act.mem_r_addr_sel),
      .mem_w_addr_sel_o    (act.mem_w_addr_sel),
      .rf_w_data_sel_o     (act.rf_w_data_sel),
      .rf_w_addr_sel_o     (act.rf_w_addr_sel),
      .rf_w_wr_o           (act.rf_w_wr),
      .rf_rp_addr_sel_o    (act.rf_rp_addr_sel),
      .rf_rp_rd_o          (act.rf_rp_rd),
      .rf_rq_rd_o          (act.rf_rq_rd),
      .temp_ld_o           (act.temp_ld),
      .nzp_ld_o            (act.nzp_ld),
      .nzp_clr_o           (act.nzp_clr),
      .alu_sel_o           (act.alu_sel),
      .alu_first_val_sel_o (act.alu_first_val_sel),
      .halted_o            (act.halted)
   );

   always #5 clk = ~clk;

   out_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Model: position within the current instruction (0 = fetch, 1 = decode,
   // 2 = execute, 3 = second execute) plus a sticky halted flag.
   int   m_step = 0;
   bit   m_halt = 1'b0;

   function automatic out_t model_out(bit r, bit hlt, int step, logic [15:0] i, bit nz);
      out_t       o;
      logic [3:0] op;
      o  = '0;
      op = i[15:12];
      if (r) return o;
      if (hlt) begin
         o.halted = 1'b1;
         return o;
      end
      if (step == 0) begin
         o.mem_rd = 1'b1; o.ir_ld = 1'b1; o.pc_inc = 1'b1;
      end else if (step == 2) begin
         case (op)
            4'h1, 4'h5: begin
               o.rf_rp_rd = 1'b1; o.rf_rq_rd = 1'b1;
               o.alu_sel = (op == 4'h1) ? 2'd0 : 2'd1;
               o.alu_first_val_sel = i[5];
               o.rf_w_wr = 1'b1; o.nzp_ld = 1'b1;
            end
            4'h9: begin
               o.rf_rp_rd = 1'b1; o.alu_sel = 2'd2; o.rf_w_wr = 1'b1; o.nzp_ld = 1'b1;
            end
            4'h0: o.pc_ld = nz;
            4'hC: begin
               o.rf_rp_rd = 1'b1; o.pc_ld = 1'b1; o.pc_sel = 2'd2;
            end
            4'h4: begin
               o.rf_w_wr = 1'b1; o.rf_w_addr_sel = 1'b1; o.rf_w_data_sel = 2'd3;
               o.pc_ld = 1'b1; o.pc_sel = i[11] ? 2'd1 : 2'd2; o.rf_rp_rd = ~i[11];
            end
            4'h2: begin
               o.mem_rd = 1'b1; o.mem_r_addr_sel = 2'd1;
               o.rf_w_wr = 1'b1; o.rf_w_data_sel = 2'd1; o.nzp_ld = 1'b1;
            end
            4'h6: begin
               o.rf_rp_rd = 1'b1; o.mem_rd = 1'b1; o.mem_r_addr_sel = 2'd2;
               o.rf_w_wr = 1'b1; o.rf_w_data_sel = 2'd1; o.nzp_ld = 1'b1;
            end
            4'hE: begin
               o.rf_w_wr = 1'b1; o.rf_w_data_sel = 2'd2;
            end
            4'h3: begin
               o.rf_rp_rd = 1'b1; o.rf_rp_addr_sel = 1'b1; o.mem_wr = 1'b1;
            end
            4'h7: begin
               o.rf_rp_rd = 1'b1; o.rf_rp_addr_sel = 1'b1; o.rf_rq_rd = 1'b1;
               o.mem_wr = 1'b1; o.mem_w_addr_sel = 2'd1;
            end
            4'hA, 4'hB: begin
               o.mem_rd = 1'b1; o.mem_r_addr_sel = 2'd1; o.temp_ld = 1'b1;
            end
            default: ;
         endcase
      end else if (step == 3) begin
         if (op == 4'hA) begin
            o.mem_rd = 1'b1; o.mem_r_addr_sel = 2'd3;
            o.rf_w_wr = 1'b1; o.rf_w_data_sel = 2'd1; o.nzp_ld = 1'b1;
         end else if (op == 4'hB) begin
            o.rf_rp_rd = 1'b1; o.rf_rp_addr_sel = 1'b1;
            o.mem_wr = 1'b1; o.mem_w_addr_sel = 2'd2;
         end
      end
      return o;
   endfunction

   // One clock cycle: drive inputs after the edge, queue the expected
   // outputs, then advance the model to where it will be after the next edge.
   task automatic cycle(input bit r, input logic [15:0] i, input bit nz);
      @(posedge clk);
      #1;
      rst       = r;
      ir        = i;
      nzp_match = nz;
      exp_q.push_back(model_out(r, m_halt, m_step, i, nz));
      if (r) begin
         m_step = 0;
         m_halt = 1'b0;
      end else if (!m_halt) begin
         case (m_step)
            0: m_step = 1;
            1: if (i[15:12] == 4'hF) m_halt = 1'b1; else m_step = 2;
            2: m_step = (i[15:12] == 4'hA || i[15:12] == 4'hB) ? 3 : 0;
            default: m_step = 0;
         endcase
      end
   endtask

   // Run one whole instruction (stops at its next fetch or on halt).
   task automatic instr(input logic [15:0] i, input bit nz);
      for (int k = 0; k < 6; k++) begin
         cycle(1'b0, i, nz);
         if (m_step == 0 || m_halt) break;
      end
   endtask

   initial begin : monitor
      out_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL outputs cycle %0d: got %h expected %h (rst=%0b ir=%h nzp=%0b)",
                        cyc, act, e, rst, ir, nzp_match);
            end
         end
         cyc++;
      end
   end

   initial begin : stimulus
      logic [15:0] cur_ir;
      bit          r;
      cur_ir = 16'h0000;

      // Reset for two cycles, then ADD R0,R1,R2 and the following fetch.
      cycle(1'b1, 16'h1042, 1'b0);
      cycle(1'b1, 16'h1042, 1'b0);
      instr(16'h1042, 1'b0);
      cycle(1'b0, 16'h1042, 1'b0);
      cycle(1'b0, 16'h1042, 1'b0);
      cycle(1'b1, 16'h1042, 1'b0);

      // Branch not taken, then taken.
      instr(16'h0A05, 1'b0);
      instr(16'h0A05, 1'b1);
      // Indirect load, JSR, JSRR R7, ADD immediate.
      instr(16'hA203, 1'b0);
      instr(16'h4801, 1'b0);
      instr(16'h41C0, 1'b0);
      instr(16'h1062, 1'b0);
      cycle(1'b0, 16'h1062, 1'b0);

      // HALT: absorbing for 20 cycles, then a reset pulse.
      cycle(1'b1, 16'h0000, 1'b0);
      instr(16'hF025, 1'b1);
      repeat (20) cycle(1'b0, 16'hF025, 1'b1);
      cycle(1'b1, 16'hF025, 1'b0);
      instr(16'h1042, 1'b0);

      // STI abandoned by reset during its execute cycle.
      cycle(1'b1, 16'h0000, 1'b0);
      cycle(1'b0, 16'hB405, 1'b0);
      cycle(1'b0, 16'hB405, 1'b0);
      cycle(1'b1, 16'hB405, 1'b0);
      cycle(1'b1, 16'hB405, 1'b0);
      instr(16'h3E01, 1'b0);
      instr(16'hB405, 1'b0);

      // Random instruction stream with occasional resets (more likely once halted).
      for (int n = 0; n < 800; n++) begin
         if (m_step == 0 && !m_halt) cur_ir = 16'($urandom);
         r = ($urandom_range(0, 39) == 0) || (m_halt && $urandom_range(0, 5) == 0);
         cycle(r, cur_ir, 1'($urandom_range(0, 1)));
      end

      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
